carry_resolve_seq: RTL

CARRY_RESOLVE_SEQ -- requirements
Module: carry_resolve_seq

---
 rtl/carry_resolve_pkg.sv | 10 +
 rtl/crs_ha_step.sv | 20 ++
 rtl/carry_resolve_seq.sv | 89 ++++++++
 3 files changed

// File: rtl/carry_resolve_pkg.sv
// carry_resolve_pkg: shared FSM state type and default width for carry_resolve_seq.
package carry_resolve_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RESOLVE = 2'b01,
        DONE    = 2'b10
    } crs_state_t;

    localparam int CRS_N_DEFAULT = 8;
endpackage

// File: rtl/crs_ha_step.sv
// crs_ha_step: one carry-resolution iteration, a row of N half adders over (s, c<<1).
module crs_ha_step
    import carry_resolve_pkg::*;
#(
    parameter int N = CRS_N_DEFAULT
) (
    input  logic [N-1:0] s,
    input  logic [N-1:0] c,
    output logic [N-1:0] s_next,
    output logic [N-1:0] c_next
);
    logic [N-1:0] cs;

    assign cs = c << 1;

    for (genvar i = 0; i < N; i++) begin : g_ha
        assign s_next[i] = s[i] ^ cs[i];
        assign c_next[i] = s[i] & cs[i];
    end
endmodule

// File: rtl/carry_resolve_seq.sv
// carry_resolve_seq: resolves a half-adder (sum, carry) pair into a full sum by iterated half-add steps.
// Defining CARRY_RESOLVE_ITER_EN adds out_iters, the iteration count reported while in DONE.
module carry_resolve_seq
    import carry_resolve_pkg::*;
#(
    parameter int N = CRS_N_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N-1:0]             in_sum,
    input  logic [N-1:0]             in_cout,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N-1:0]             out_result,
    output logic                     out_carry
`ifdef CARRY_RESOLVE_ITER_EN
    ,
    output logic [$clog2(N+1)-1:0]   out_iters
`endif
);
    localparam int IW = $clog2(N+1);
    localparam logic [IW-1:0] ITER_MAX = IW'(N);

    crs_state_t state, state_next;
    logic [N-1:0] s, c, s_step, c_step;
    logic [IW-1:0] iter;
    logic ovf, accept, busy;

    crs_ha_step #(.N(N)) u_step (
        .s      (s),
        .c      (c),
        .s_next (s_step),
        .c_next (c_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid) state_next = RESOLVE;
            end
            RESOLVE: if (c == '0) state_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;
    assign busy   = (state == RESOLVE) && (c != '0);

    // The carry shifted out of bit N-1 is the only source of the final carry-out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s    <= '0;
            c    <= '0;
            ovf  <= 1'b0;
            iter <= '0;
        end else if (accept) begin
            s    <= in_sum;
            c    <= in_cout;
            ovf  <= 1'b0;
            iter <= '0;
        end else if (busy) begin
            s   <= s_step;
            c   <= c_step;
            ovf <= ovf | c[N-1];
            if (iter != ITER_MAX) iter <= iter + IW'(1);
        end
    end

    assign out_result = s;
    assign out_carry  = ovf;
`ifdef CARRY_RESOLVE_ITER_EN
    assign out_iters = (state == DONE) ? iter : '0;
`endif
endmodule
